// File: rtl/sha256_pad_ctrl.sv
// SHA-256 padding controller: packs 32-bit words into 512-bit blocks, then appends the 0x80 marker, zero fill and 64-bit length.
// Block valid the cycle after the 16th or last word; in_ready stays low while a block waits for blk_ready.
module sha256_pad_ctrl #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last,
    output logic         busy
);

    typedef enum logic [1:0] {S_FILL, S_BLK, S_XTRA} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_buf [16];
    logic [3:0]       r_widx;
    logic [LEN_W-1:0] r_bitlen;
    logic             r_fin;
    logic             r_mark_pending;
    logic             r_xtra;
    logic             r_busy;

    logic             w_accept;
    logic [2:0]       w_n;
    logic             w_full;
    logic [4:0]       w_p;
    logic [LEN_W-1:0] w_bitlen_nxt;
    logic [63:0]      w_len64;
    logic [31:0]      w_last_word;
    logic [511:0]     w_blk_data;

    assign in_ready  = (r_state == S_FILL) && rst_n;
    assign blk_valid = (r_state != S_FILL);
    assign busy      = r_busy;
    assign w_accept  = in_ready && in_valid;

    assign w_n    = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
    assign w_full = (w_n == 3'd4);
    // p is the word index that receives the 0x80 marker
    assign w_p    = {1'b0, r_widx} + {4'b0000, w_full};

    assign w_bitlen_nxt = in_last ? (r_bitlen + LEN_W'({w_n, 3'b000}))
                                  : (r_bitlen + LEN_W'(32));
    assign w_len64      = 64'(w_bitlen_nxt);

    always_comb begin
        w_last_word = 32'h8000_0000;
        case (w_n)
            3'd1:    w_last_word = {in_data[31:24], 24'h80_0000};
            3'd2:    w_last_word = {in_data[31:16], 16'h8000};
            3'd3:    w_last_word = {in_data[31:8], 8'h80};
            3'd4:    w_last_word = in_data;
            default: w_last_word = 32'h8000_0000;
        endcase
    end

    always_comb begin
        w_blk_data = '0;
        for (int i = 0; i < 16; i++) begin
            w_blk_data[511-32*i -: 32] = r_buf[i];
        end
    end

    always_comb begin
        blk_last = 1'b0;
        blk_data = '0;
        case (r_state)
            S_BLK: begin
                blk_last = r_fin;
                blk_data = w_blk_data;
            end
            S_XTRA: begin
                blk_last = 1'b1;
                blk_data = {(r_mark_pending ? 32'h8000_0000 : 32'h0), 416'h0, 64'(r_bitlen)};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL: if (w_accept && (in_last || r_widx == 4'd15)) w_state_nxt = S_BLK;
            S_BLK:  if (blk_ready) w_state_nxt = r_xtra ? S_XTRA : S_FILL;
            S_XTRA: if (blk_ready) w_state_nxt = S_FILL;
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) r_buf[i] <= '0;
            r_widx         <= '0;
            r_bitlen       <= '0;
            r_fin          <= 1'b0;
            r_mark_pending <= 1'b0;
            r_xtra         <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_busy   <= 1'b1;
                        r_bitlen <= w_bitlen_nxt;
                        if (!in_last) begin
                            r_buf[r_widx] <= in_data;
                            r_widx        <= r_widx + 4'd1;
                            r_fin         <= 1'b0;
                            r_xtra        <= 1'b0;
                        end else begin
                            r_buf[r_widx] <= w_last_word;
                            if (w_full && r_widx != 4'd15) r_buf[r_widx + 4'd1] <= 32'h8000_0000;
                            if (w_p <= 5'd13) begin
                                r_buf[14] <= w_len64[63:32];
                                r_buf[15] <= w_len64[31:0];
                            end
                            r_fin          <= (w_p <= 5'd13);
                            r_xtra         <= (w_p >= 5'd14);
                            r_mark_pending <= (w_p == 5'd16);
                        end
                    end
                end
                S_BLK: begin
                    if (blk_ready) begin
                        for (int i = 0; i < 16; i++) r_buf[i] <= '0;
                        r_widx <= '0;
                        if (r_fin) begin
                            r_bitlen <= '0;
                            r_busy   <= 1'b0;
                            r_fin    <= 1'b0;
                        end
                    end
                end
                S_XTRA: begin
                    if (blk_ready) begin
                        r_mark_pending <= 1'b0;
                        r_bitlen       <= '0;
                        r_xtra         <= 1'b0;
                        r_busy         <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_pad_ctrl.sv
// Bench for sha256_pad_ctrl: byte-level SHA-256 padding model, per-cycle output compare, directed and random messages.
`timescale 1ns/1ps
module tb_sha256_pad_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic [2:0]   in_nbytes = '0;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic [511:0] blk_data;
    logic         blk_last;
    logic         busy;

    always #5 clk = ~clk;

    sha256_pad_ctrl #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last),
        .busy      (busy)
    );

    int           n_chk = 0;
    int           n_fail = 0;
    int           rd_idx = 0;
    int           rdy_mode = 2;
    logic         busy_exp = 1'b0;
    logic [7:0]   msg_q[$];
    logic [511:0] mdl_blk[$];
    logic [511:0] exp_blk_q[$];
    logic         exp_last_q[$];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Standard SHA-256 padding of msg_q, split into 64-byte blocks
    function automatic void pad_model();
        logic [7:0]   pad[$];
        logic [63:0]  bl;
        logic [511:0] b;
        pad = msg_q;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        bl = 64'(msg_q.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) pad.push_back(bl[8*i +: 8]);
        mdl_blk.delete();
        for (int k = 0; k < pad.size() / 64; k++) begin
            b = '0;
            for (int j = 0; j < 64; j++) b[511-8*j -: 8] = pad[64*k+j];
            mdl_blk.push_back(b);
        end
    endfunction

    function automatic void fill_msg(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       blk_ready = ($urandom_range(0, 2) != 0);
                1:       blk_ready = 1'b0;
                default: blk_ready = 1'b1;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_exp = 1'b0;
                rd_idx   = exp_blk_q.size();
            end else begin
                check("busy", 512'(busy), 512'(busy_exp));
                if (blk_valid) begin
                    check("in_ready_while_blk", 512'(in_ready), 512'(0));
                    if (rd_idx >= exp_blk_q.size()) begin
                        check("unexpected_blk_valid", 512'(blk_valid), 512'(0));
                    end else begin
                        check("blk_data", blk_data, exp_blk_q[rd_idx]);
                        check("blk_last", 512'(blk_last), 512'(exp_last_q[rd_idx]));
                        if (blk_ready) begin
                            if (exp_last_q[rd_idx]) busy_exp = 1'b0;
                            rd_idx++;
                        end
                    end
                end
                if (in_valid && in_ready) busy_exp = 1'b1;
            end
        end
    end

    task automatic wait_accept();
        int t = 0;
        bit acc = 0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
            if (!acc && t > 2000) begin
                check("accept_timeout", 512'(in_ready), 512'(1));
                break;
            end
        end
    endtask

    task automatic send_msg(input int len, input int abort_after, input bit tail_ok, input bit gaps);
        int nw;
        int last_n;
        logic [31:0] w;
        fill_msg(len);
        nw = (len + 3) / 4;
        if (nw == 0) nw = 1;
        last_n = len - 4 * (nw - 1);
        if (tail_ok && len > 0 && len % 4 == 0 && $urandom_range(0, 2) == 0) begin
            nw++;
            last_n = 0;
        end
        if (abort_after < 0) begin
            pad_model();
            for (int i = 0; i < mdl_blk.size(); i++) begin
                exp_blk_q.push_back(mdl_blk[i]);
                exp_last_q.push_back(i == mdl_blk.size() - 1);
            end
        end
        for (int k = 0; k < nw; k++) begin
            if (k == abort_after) break;
            while (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            w = $urandom;
            for (int b = 0; b < 4; b++) begin
                if (4*k + b < len) w[31-8*b -: 8] = msg_q[4*k+b];
            end
            in_data  = w;
            in_valid = 1'b1;
            in_last  = (k == nw - 1);
            if (in_last) begin
                if (last_n == 4 && $urandom_range(0, 1) == 1) in_nbytes = 3'($urandom_range(5, 7));
                else in_nbytes = 3'(last_n);
            end else begin
                in_nbytes = 3'($urandom);
            end
            wait_accept();
            in_valid = 1'b0;
            if (k == nw - 1 || (k + 1) % 16 == 0) begin
                @(negedge clk);
                check("blk_valid_latency", 512'(blk_valid), 512'(1));
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (rd_idx < exp_blk_q.size() && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check("drain", 512'(rd_idx), 512'(exp_blk_q.size()));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_blk_valid"}, 512'(blk_valid), 512'(0));
        check({tag, "_blk_last"}, 512'(blk_last), 512'(0));
        check({tag, "_blk_data"}, blk_data, 512'(0));
        check({tag, "_busy"}, 512'(busy), 512'(0));
        check({tag, "_in_ready"}, 512'(in_ready), 512'(0));
    endtask

    logic [511:0] d0;

    initial begin
        // Pin the model against hand-computed padded blocks
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
        pad_model();
        check("model_abc_nblk", 512'(mdl_blk.size()), 512'(1));
        check("model_abc", mdl_blk[0], {32'h6162_6380, 448'h0, 32'h0000_0018});
        fill_msg(55); pad_model();
        check("model_55_nblk", 512'(mdl_blk.size()), 512'(1));
        check("model_55_w13", 512'(mdl_blk[0][71:64]), 512'(8'h80));
        check("model_55_w15", 512'(mdl_blk[0][31:0]), 512'(32'h0000_01B8));
        fill_msg(56); pad_model();
        check("model_56_nblk", 512'(mdl_blk.size()), 512'(2));
        check("model_56_w14", 512'(mdl_blk[0][63:32]), 512'(32'h8000_0000));
        check("model_56_x", mdl_blk[1], {448'h0, 64'h1C0});
        fill_msg(64); pad_model();
        check("model_64_x", mdl_blk[1], {32'h8000_0000, 416'h0, 64'h200});
        fill_msg(0); pad_model();
        check("model_empty", mdl_blk[0], {32'h8000_0000, 480'h0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", 512'(in_ready), 512'(1));
        @(posedge clk);
        #1;

        rdy_mode = 2;
        send_msg(3, -1, 0, 0);  drain();
        send_msg(55, -1, 0, 0); drain();
        send_msg(56, -1, 0, 0); drain();
        send_msg(64, -1, 0, 0); drain();
        send_msg(0, -1, 0, 0);  drain();

        rdy_mode = 1;
        send_msg(3, -1, 0, 0);
        @(negedge clk);
        d0 = blk_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_stable", blk_data, d0);
            check("bp_valid", 512'(blk_valid), 512'(1));
        end
        @(posedge clk);
        #1;
        rdy_mode = 2;
        drain();

        send_msg(3, -1, 0, 0);
        send_msg(20, -1, 0, 0);
        send_msg(60, -1, 0, 0);
        drain();

        send_msg(40, 7, 0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_release", 512'(in_ready), 512'(1));
        @(posedge clk);
        #1;
        send_msg(3, -1, 0, 0);
        drain();

        rdy_mode = 0;
        for (int m = 0; m < 40; m++) begin
            send_msg($urandom_range(0, 150), -1, 1, 1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_pad_ctrl.md
# sha256_pad_ctrl

Streaming SHA-256 message-padding controller. Accepts a message as a sequence of 32-bit big-endian words with valid/ready handshake, packs it into 512-bit blocks, appends the 0x80 marker, zero fill and 64-bit bit-length. When the padding does not fit in the final data block, it emits one extra block. Sits between the message source and the SHA-256 compression core and presents one 512-bit block at a time.

## Interface
- LEN_W, 64, width of the internal bit-length counter (≤64); zero-extended into the 64-bit length field.

- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- in_valid  in  1  input word valid
- in_ready  out  1  controller can accept a word
- in_data  in  32  message word; byte 0 = in_data[31:24]
- in_last  in  1  word is the last of the message
- in_nbytes  in  3  valid bytes in the last word, 0..4, left-aligned; ignored unless in_last; values 5..7 are treated as 4
- blk_valid  out  1  block available
- blk_ready  in  1  consumer accepts block
- blk_data  out  512  block; word 0 = bits [511:480]
- blk_last  out  1  block is the final (length-bearing) block of the message
- busy  out  1  high from the first accepted word of a message until its final block handshake

## Operation
- Registers: 16×32 buffer, word index widx (0..15), bitlen (LEN_W), state ∈ {FILL, BLK, XTRA}, flags fin (current BLK is final) and mark_pending (0x80 still owed).
- FILL: in_ready=1. On an accepted non-last word, write buffer[widx], bitlen += 32, widx++.
  - If widx was 15: go to BLK with fin=0.
- Accepted last word with n = in_nbytes:
  - Write bytes 0..n-1 of buffer[widx]. If n<4, byte n = 0x80 and later bytes are 0. If n=4, 0x80 goes to byte 0 of word widx+1.
  - bitlen += 8n. All words above the marker word are 0.
  - Let p = widx + (n==4).
    - p ≤ 13: words 14/15 = 64-bit bitlen (final value, high word in 14). Go to BLK with fin=1.
    - 14 ≤ p ≤ 15: 0x80 is placed in the block. Go to BLK with fin=0; XTRA follows.
    - p = 16: go to BLK with fin=0 and mark_pending=1; XTRA follows.
- BLK: blk_valid=1, blk_data=buffer, blk_last=fin. On handshake:
  - Clear the buffer and set widx=0.
  - If an extra block is owed, go to XTRA. Otherwise go to FILL.
  - If fin: clear bitlen and busy.
- XTRA: blk_valid=1, blk_last=1, blk_data = {mark_pending ? 0x80000000 : 0, 13 zero words, 64-bit bitlen}.
  - On handshake: clear mark_pending and bitlen, go to FILL.
- Empty message: in_last with n=0 at widx=0 gives block word0=0x80000000, length 0.
- bitlen wraps modulo 2^LEN_W; no overflow flag.
- in_ready=0 in BLK and XTRA; in_data is ignored there.

## Timing
- Reset (rst_n=0 sampled at a clk edge) gives:
  - state=FILL, widx=0, bitlen=0, buffer=0, fin=0, mark_pending=0.
  - Outputs: blk_valid=0, blk_last=0, blk_data=0, busy=0.
  - in_ready=0 while rst_n=0, and 1 on the first cycle after release.
- A reset asserted mid-message or mid-BLK/XTRA discards everything. No partial block is emitted.
- Word accepted at edge t (16th word or last word) → blk_valid=1 from cycle t+1.
- blk_data and blk_last stay stable while blk_valid=1 and blk_ready=0.
- Block handshake at edge t:
  - XTRA block visible in cycle t+1, or
  - in_ready=1 in cycle t+1 (FILL).
- Maximum throughput is 17 cycles per block: 16 word cycles plus 1 block cycle. No combinational path from in_valid to in_ready, or from blk_ready to blk_valid.

## Test plan
- "abc": one word 0x61626300 with last and n=3 → one block: word0=0x61626380, words 1..14=0, word15=0x00000018, blk_last=1, busy falls after handshake.
- 55-byte message (last at widx=13, n=3) → single block with 0x80 in the low byte of word 13 and word15=0x000001B8. 56-byte message (last at widx=13, n=4) → block 1 word14=0x80000000 with blk_last=0, then XTRA with word15=0x000001C0 and blk_last=1.
- 64-byte message (last at widx=15, n=4) → block 1 contains raw data with blk_last=0. XTRA word0=0x80000000, word15=0x00000200.
- Empty message (n=0 at widx=0) → word0=0x80000000, rest 0, blk_last=1.
- Backpressure: hold blk_ready=0 for 5 cycles in BLK → blk_data stable, in_ready=0, no words consumed. Back-to-back messages: bitlen restarts at 0.
- Assert rst_n=0 after 7 words of a message → all outputs at reset values. A following "abc" message produces exactly the first scenario's block.
